// File: rtl/root_child_sequencer.sv
// Launch/completion sequencer for a root module's child instances.
// Starts children one at a time or all at once, collects done handshakes and reports timeouts.
module root_child_sequencer #(
  parameter  int NUM_CHILD = 5,
  parameter  int TIMEOUT_W = 8,
  localparam int IDX_W     = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode_par,
  input  logic [TIMEOUT_W-1:0] timeout_cyc,
  output logic [NUM_CHILD-1:0] child_start,
  input  logic [NUM_CHILD-1:0] child_done,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [IDX_W-1:0]     err_idx
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FINISH} state_t;

  state_t               state, state_nxt;
  logic                 mode_q;
  logic [TIMEOUT_W-1:0] tmo_q;
  logic [TIMEOUT_W-1:0] timer;
  logic [IDX_W-1:0]     cur_idx;
  logic [NUM_CHILD-1:0] seen;

  logic [NUM_CHILD-1:0] hit_mask;
  logic                 complete;
  logic                 timeout_hit;
  logic                 last;
  logic [IDX_W-1:0]     lowest_unseen;

  logic [NUM_CHILD-1:0] child_start_nxt;
  logic                 busy_nxt;
  logic                 done_nxt;

  // Completion and timeout qualifiers, only meaningful in WAIT
  always_comb begin
    hit_mask    = seen | child_done;
    complete    = mode_q ? (&hit_mask) : child_done[cur_idx];
    timeout_hit = (tmo_q != '0) && (timer == tmo_q) && !complete;
    last        = (cur_idx == IDX_W'(NUM_CHILD - 1));
    lowest_unseen = '0;
    for (int i = NUM_CHILD - 1; i >= 0; i--)
      if (!hit_mask[i]) lowest_unseen = IDX_W'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = LAUNCH;
      LAUNCH: state_nxt = WAIT;
      WAIT: begin
        if (complete)         state_nxt = (mode_q || last) ? FINISH : LAUNCH;
        else if (timeout_hit) state_nxt = FINISH;
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead so that every port comes straight from a flop
  always_comb begin
    child_start_nxt = '0;
    if (state == IDLE && start)
      child_start_nxt = mode_par ? '1 : NUM_CHILD'(1);
    else if (state == WAIT && state_nxt == LAUNCH)
      child_start_nxt = NUM_CHILD'(1) << (cur_idx + IDX_W'(1));
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      child_start <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      child_start <= child_start_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= 1'b0;
      tmo_q   <= '0;
      timer   <= '0;
      cur_idx <= '0;
      seen    <= '0;
      err     <= 1'b0;
      err_idx <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mode_q  <= mode_par;
          tmo_q   <= timeout_cyc;
          err     <= 1'b0;
          err_idx <= '0;
          cur_idx <= '0;
          seen    <= '0;
        end
        LAUNCH: timer <= '0;
        WAIT: begin
          if (timer != '1) timer <= timer + TIMEOUT_W'(1);
          if (mode_q) seen <= hit_mask;
          if (complete && !mode_q && !last) cur_idx <= cur_idx + IDX_W'(1);
          if (timeout_hit) begin
            err     <= 1'b1;
            err_idx <= mode_q ? lowest_unseen : cur_idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_root_child_sequencer.sv
// Directed bench for root_child_sequencer: sequential, parallel, timeout, collision and reset cases.
module tb_root_child_sequencer;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode_par = 1'b0;
  logic [7:0]   timeout_cyc = '0;
  logic [N-1:0] child_done = '0;
  logic [N-1:0] child_start;
  logic         busy, done, err;
  logic [2:0]   err_idx;

  int checks = 0;
  int failures = 0;

  root_child_sequencer #(.NUM_CHILD(N), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_par(mode_par),
    .timeout_cyc(timeout_cyc), .child_start(child_start), .child_done(child_done),
    .busy(busy), .done(done), .err(err), .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int n, input int cs, input int dn,
                         input int bs, input int er, input int ei);
    chk($sformatf("%s[%0d].child_start", tag, n), 32'(child_start), cs);
    chk($sformatf("%s[%0d].done", tag, n), 32'(done), dn);
    chk($sformatf("%s[%0d].busy", tag, n), 32'(busy), bs);
    chk($sformatf("%s[%0d].err", tag, n), 32'(err), er);
    chk($sformatf("%s[%0d].err_idx", tag, n), 32'(err_idx), ei);
  endtask

  // Each child answers with a one-cycle done 3 cycles after its start pulse
  task automatic seq_gap3(input string tag, input int tmo, input bit inject);
    mode_par = 1'b0; timeout_cyc = 8'(tmo); start = 1'b1;
    cyc();
    start = 1'b0;
    for (int n = 0; n <= 22; n++) begin
      chk_all(tag, n, (n % 4 == 0 && n <= 16) ? (1 << (n / 4)) : 0,
              int'(n == 20), int'(n <= 20), 0, 0);
      child_done = (n >= 3 && (n - 3) % 4 == 0 && n <= 19) ? N'(1 << ((n - 3) / 4)) : '0;
      start = inject && (n == 5 || n == 20);
      cyc();
    end
    child_done = '0; start = 1'b0;
  endtask

  initial begin
    // Reset state
    cyc(); cyc();
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc();

    // Sequential, timeout disabled
    seq_gap3("seq", 0, 1'b0);

    // Parallel, done order 4,2,0,3,1
    mode_par = 1'b1; timeout_cyc = 8'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int n = 0; n <= 13; n++) begin
      chk_all("par", n, (n == 0) ? 32'h1f : 0, int'(n == 11), int'(n <= 11), 0, 0);
      case (n)
        2:       child_done = 5'b10000;
        4:       child_done = 5'b00100;
        6:       child_done = 5'b00001;
        8:       child_done = 5'b01000;
        10:      child_done = 5'b00010;
        default: child_done = 5'b00000;
      endcase
      cyc();
    end
    child_done = '0;

    // Sequential timeout, child 2 silent
    mode_par = 1'b0; timeout_cyc = 8'd6; child_done = 5'b11011; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int n = 0; n <= 14; n++) begin
      chk_all("seq_tmo", n, (n == 0) ? 1 : (n == 2) ? 2 : (n == 4) ? 4 : 0,
              int'(n == 12), int'(n <= 12), int'(n >= 12), (n >= 12) ? 2 : 0);
      cyc();
    end
    child_done = '0;

    // Parallel timeout, children 1 and 3 silent; also shows err cleared by the new start
    mode_par = 1'b1; timeout_cyc = 8'd4; child_done = 5'b10101; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int n = 0; n <= 8; n++) begin
      chk_all("par_tmo", n, (n == 0) ? 32'h1f : 0, int'(n == 6), int'(n <= 6),
              int'(n >= 6), (n >= 6) ? 1 : 0);
      cyc();
    end
    child_done = '0;

    // Done on the exact timeout cycle, with stray starts in WAIT and FINISH
    seq_gap3("collide", 2, 1'b1);

    // Reset while waiting on child 2
    mode_par = 1'b0; timeout_cyc = 8'd0; child_done = 5'b00011; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int n = 0; n <= 5; n++) begin
      chk_all("pre_rst", n, (n == 0) ? 1 : (n == 2) ? 2 : (n == 4) ? 4 : 0, 0, 1, 0, 0);
      if (n < 5) cyc();
    end
    rst_n = 1'b0;
    #1;
    chk_all("in_rst", 0, 0, 0, 0, 0, 0);
    for (int n = 1; n <= 3; n++) begin
      cyc();
      chk_all("in_rst", n, 0, 0, 0, 0, 0);
    end
    rst_n = 1'b1; child_done = '0; start = 1'b1;
    cyc();
    start = 1'b0;
    chk_all("post_rst", 0, 1, 0, 1, 0, 0);
    cyc();
    chk_all("post_rst", 1, 0, 0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/root_child_sequencer.md
# root_child_sequencer

Parametrised launch/completion sequencer for a root module's child instances. It replaces fixed, unconnected child instantiation with a controlled bring-up. It issues a one-cycle start pulse to each of NUM_CHILD children, either one at a time in index order or all at once. It collects per-child done handshakes, enforces a per-launch timeout, and reports overall completion and the first failing child to the parent level.

## Interface
- NUM_CHILD, 5: number of child channels, 1..32.
- TIMEOUT_W, 8: width of the timeout counter and the timeout_cyc input.
- IDX_W, max(1,$clog2(NUM_CHILD)): width of err_idx (derived; do not override).

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  run request, sampled only in IDLE.
- mode_par  in  1  0 = sequential, 1 = parallel; sampled with start.
- timeout_cyc  in  TIMEOUT_W  per-launch WAIT limit; 0 disables the timeout; sampled with start.
- child_start  out  NUM_CHILD  one-cycle launch pulses.
- child_done  in  NUM_CHILD  child completion, level or pulse; honoured only in WAIT.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle run-complete pulse.
- err  out  1  sticky timeout flag; cleared by the next accepted start.
- err_idx  out  IDX_W  failing child index; valid while err=1.

## Operation
- Reset values: child_start=0, busy=0, done=0, err=0, err_idx=0; FSM in IDLE; cur_idx=0; seen mask=0; timer=0.
- States: IDLE, LAUNCH, WAIT, FINISH.
- IDLE -> LAUNCH on start=1.
  - Latch mode_par and timeout_cyc.
  - Clear err, err_idx, cur_idx and the seen mask.
- LAUNCH (1 cycle) -> WAIT.
  - Sequential: child_start[cur_idx]=1.
  - Parallel: child_start = all ones.
  - Clear the timer.
- WAIT, sequential:
  - child_done[cur_idx]=1 and cur_idx<NUM_CHILD-1: increment cur_idx, go to LAUNCH.
  - child_done[cur_idx]=1 and cur_idx=NUM_CHILD-1: go to FINISH.
  - Other child_done bits are ignored.
- WAIT, parallel:
  - seen |= child_done each cycle.
  - When (seen | child_done) is all ones: go to FINISH.
- Timeout: the timer increments each WAIT cycle, saturating. When timer==timeout_cyc (nonzero) and the completion condition is false:
  - Set err=1.
  - err_idx = cur_idx (sequential) or the lowest index not yet seen (parallel).
  - Go to FINISH. Remaining children are not launched.
- Done and timeout in the same cycle: done wins, err stays 0.
- FINISH (1 cycle): done=1, then IDLE. err and err_idx hold until the next accepted start.
- start while busy is ignored and not queued. start in the FINISH cycle is ignored.
- NUM_CHILD=1: both modes behave identically.
- Reset mid-run: all outputs return to reset values asynchronously. No done is produced for the aborted run.

## Timing
- Accepted start at edge t: LAUNCH during cycle t+1 (child_start high), WAIT from t+2.
- Sequential: child_done[i] seen in cycle k -> child_start[i+1] in cycle k+1. Inter-launch gap = 1 cycle plus the child's response time.
- The last completion seen in cycle k -> done=1 in cycle k+1 -> IDLE at k+2. The earliest next accept is at the k+2 edge.
- A child that answers immediately (done high in the first WAIT cycle) costs 2 cycles per child. Sequential minimum run = 2*NUM_CHILD+2 cycles from start.
- Timeout: the first WAIT cycle has timer=0. The timeout fires in WAIT cycle number timeout_cyc+1 of that launch; FINISH follows next cycle.
- All outputs are registered. There are no combinational paths from input to output.

## Test plan
- Sequential, NUM_CHILD=5, timeout_cyc=0, each child asserts done 3 cycles after its start:
  - child_start pulses 0..4 in order, 4 cycles apart.
  - done pulses exactly once; err=0; busy falls the cycle after done.
- Parallel, done order 4,2,0,3,1 spread over 10 cycles:
  - child_start=5'b11111 for one cycle.
  - done arrives the cycle after child 1's done; err=0.
- Sequential, timeout_cyc=6, child 2 never answers:
  - err=1, err_idx=2, done pulses.
  - child_start[3] and child_start[4] never assert.
  - The next start clears err.
- Parallel, timeout_cyc=4, children 1 and 3 silent:
  - err=1, err_idx=1, done after the timeout.
- Simultaneous events:
  - child done on the exact timeout cycle -> err=0, normal completion.
  - start pulsed during WAIT -> ignored, exactly one done.
- rst_n low during WAIT of child 2:
  - All outputs read 0 immediately and no done appears.
  - After release, a fresh start runs from child 0.
